// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file with scoreboard.
package regfile_pkg;

  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned AW        = $clog2(NREGS_DEF);
  localparam int unsigned CNT_W     = $clog2(NREGS_DEF + 1);
  localparam int unsigned MAX_WR    = 8;

  typedef logic [AW-1:0] reg_idx_t;

  // Highest set bit wins: the youngest write port in program order; -1 if none.
  function automatic int youngest_hit(input logic [MAX_WR-1:0] hit);
    int sel;
    sel = -1;
    for (int j = 0; j < MAX_WR; j++) begin
      if (hit[j]) sel = j;
    end
    return sel;
  endfunction

endpackage

// File: rtl/regfile_bypass_mux.sv
// Per-read-port operand select: youngest same-cycle write, else stored value; x0 reads 0.
module regfile_bypass_mux
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NWR    = 2,
  parameter int unsigned BYPASS = 1
) (
  input  logic [ADDR_W-1:0]      rd_addr,
  input  logic [NWR-1:0]         wr_en,
  input  logic [NWR*ADDR_W-1:0]  wr_addr,
  input  logic [NWR*XLEN-1:0]    wr_data,
  input  logic [XLEN-1:0]        stored,
  output logic [XLEN-1:0]        value
);

  logic [MAX_WR-1:0] hit;
  int                sel;

  always_comb begin
    hit = '0;
    for (int j = 0; j < NWR; j++) begin
      hit[j] = (BYPASS != 0) && wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == rd_addr);
    end
    sel   = youngest_hit(hit);
    value = stored;
    if (rd_addr == '0) begin
      value = '0;
    end else if (sel >= 0) begin
      value = wr_data[sel*XLEN +: XLEN];
    end
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with write bypass, optional registered read and a
// pending-write scoreboard used by issue to stall WAW claims.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned NRD      = 2,
  parameter int unsigned NWR      = 2,
  parameter int unsigned READ_REG = 0,
  parameter int unsigned BYPASS   = 1,
  localparam int unsigned ADDR_W  = $clog2(NREGS),
  localparam int unsigned CW      = $clog2(NREGS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [NRD*ADDR_W-1:0]  rd_addr,
  output logic [NRD*XLEN-1:0]    rd_data,
  output logic [NRD-1:0]         rd_busy,
  input  logic [NWR-1:0]         wr_en,
  input  logic [NWR*ADDR_W-1:0]  wr_addr,
  input  logic [NWR*XLEN-1:0]    wr_data,
  input  logic                   iss_valid,
  input  logic [ADDR_W-1:0]      iss_addr,
  output logic                   iss_ready,
  output logic [CW-1:0]          busy_cnt
);

  logic [XLEN-1:0]  mem_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Ascending port order so the youngest write to an address lands last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) mem_q[r] <= '0;
    end else if (en) begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] != '0)) begin
          mem_q[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*XLEN +: XLEN];
        end
      end
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [XLEN-1:0]   value;

    assign ra         = rd_addr[i*ADDR_W +: ADDR_W];
    assign rd_busy[i] = busy_q[ra];

    regfile_bypass_mux #(
      .XLEN   (XLEN),
      .ADDR_W (ADDR_W),
      .NWR    (NWR),
      .BYPASS (BYPASS)
    ) u_mux (
      .rd_addr (ra),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .stored  (mem_q[ra]),
      .value   (value)
    );

    if (READ_REG != 0) begin : g_reg
      logic [XLEN-1:0] rd_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)     rd_q <= '0;
        else if (en) rd_q <= value;
      end
      assign rd_data[i*XLEN +: XLEN] = rd_q;
    end else begin : g_comb
      assign rd_data[i*XLEN +: XLEN] = en ? value : '0;
    end
  end

  assign iss_ready = en && ((iss_addr == '0) || !busy_q[iss_addr]);

  // Writes clear first, then an accepted claim sets; a claim only succeeds on a
  // non-busy register, so a retiring write can never cancel a fresh claim.
  always_comb begin
    busy_d = busy_q;
    if (en) begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j]) busy_d[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b0;
      end
      if (iss_valid && iss_ready && (iss_addr != '0)) busy_d[iss_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
    cnt_d = '0;
    for (int r = 1; r < NREGS; r++) cnt_d = cnt_d + CW'(busy_d[r]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else if (en) begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: a combinational/bypass instance and a registered/no-bypass one.
module tb_regfile_mp_sb;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [9:0]  rd_addr;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        iss_valid;
  reg_idx_t    iss_addr;

  logic [63:0] rd_data,  rd_data_r;
  logic [1:0]  rd_busy,  rd_busy_r;
  logic        iss_ready, iss_ready_r;
  logic [5:0]  busy_cnt, busy_cnt_r;

  always #5 clk = ~clk;

  regfile_mp_sb dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .iss_ready (iss_ready),
    .busy_cnt  (busy_cnt)
  );

  regfile_mp_sb #(.READ_REG(1), .BYPASS(0)) dut_r (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data_r),
    .rd_busy   (rd_busy_r),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .iss_ready (iss_ready_r),
    .busy_cnt  (busy_cnt_r)
  );

  typedef struct {
    logic        en;
    logic [1:0]  we;
    reg_idx_t    wa0;
    logic [31:0] wd0;
    reg_idx_t    wa1;
    logic [31:0] wd1;
    reg_idx_t    ra0;
    reg_idx_t    ra1;
    logic        iv;
    reg_idx_t    ia;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
    logic [1:0]  e_busy;
    logic        e_ready;
    logic [5:0]  e_cnt;
    logic [31:0] e_rr0;
  } vec_t;

  vec_t        vecs [13];
  logic [31:0] rr_q [$];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    en        = v.en;
    wr_en     = v.we;
    wr_addr   = {v.wa1, v.wa0};
    wr_data   = {v.wd1, v.wd0};
    rd_addr   = {v.ra1, v.ra0};
    iss_valid = v.iv;
    iss_addr  = v.ia;
  endtask

  task automatic apply(input vec_t v, input int k);
    logic [31:0] exp_rr;
    @(negedge clk);
    drive(v);
    rr_q.push_back(v.e_rr0);
    #2;
    check($sformatf("v%0d rd0", k), rd_data[31:0], v.e_rd0);
    check($sformatf("v%0d rd1", k), rd_data[63:32], v.e_rd1);
    check($sformatf("v%0d busy", k), {30'd0, rd_busy}, {30'd0, v.e_busy});
    check($sformatf("v%0d ready", k), {31'd0, iss_ready}, {31'd0, v.e_ready});
    @(posedge clk);
    #1;
    check($sformatf("v%0d cnt", k), {26'd0, busy_cnt}, {26'd0, v.e_cnt});
    check($sformatf("v%0d cnt_r", k), {26'd0, busy_cnt_r}, {26'd0, v.e_cnt});
    exp_rr = rr_q.pop_front();
    check($sformatf("v%0d rd0_reg", k), rd_data_r[31:0], exp_rr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          en we   wa0  wd0           wa1  wd1           ra0  ra1  iv ia    rd0           rd1           busy  rdy cnt rr0
    vecs[0]  = '{1, 2'b00, 0, 32'h0,        0, 32'h0,        1,   31,  0, 5,  32'h0,        32'h0,        2'b00, 1, 0, 32'h0};
    vecs[1]  = '{1, 2'b11, 3, 32'hDEADBEEF, 3, 32'h12345678, 3,   4,   0, 0,  32'h12345678, 32'h0,        2'b00, 1, 0, 32'h0};
    vecs[2]  = '{1, 2'b00, 0, 32'h0,        0, 32'h0,        3,   3,   0, 0,  32'h12345678, 32'h12345678, 2'b00, 1, 0, 32'h12345678};
    vecs[3]  = '{1, 2'b01, 7, 32'hA5A5A5A5, 0, 32'h0,        7,   3,   0, 0,  32'hA5A5A5A5, 32'h12345678, 2'b00, 1, 0, 32'h0};
    vecs[4]  = '{1, 2'b00, 0, 32'h0,        0, 32'h0,        7,   0,   0, 0,  32'hA5A5A5A5, 32'h0,        2'b00, 1, 0, 32'hA5A5A5A5};
    vecs[5]  = '{1, 2'b10, 0, 32'h0,        0, 32'hFFFFFFFF, 0,   0,   1, 0,  32'h0,        32'h0,        2'b00, 1, 0, 32'h0};
    vecs[6]  = '{1, 2'b00, 0, 32'h0,        0, 32'h0,        0,   7,   0, 0,  32'h0,        32'hA5A5A5A5, 2'b00, 1, 0, 32'h0};
    vecs[7]  = '{1, 2'b00, 0, 32'h0,        0, 32'h0,        9,   0,   1, 9,  32'h0,        32'h0,        2'b00, 1, 1, 32'h0};
    vecs[8]  = '{1, 2'b01, 9, 32'h42,       0, 32'h0,        9,   0,   1, 9,  32'h42,       32'h0,        2'b01, 0, 0, 32'h0};
    vecs[9]  = '{1, 2'b00, 0, 32'h0,        0, 32'h0,        9,   0,   1, 9,  32'h42,       32'h0,        2'b00, 1, 1, 32'h42};
    vecs[10] = '{0, 2'b01, 4, 32'h55,       0, 32'h0,        4,   9,   1, 4,  32'h0,        32'h0,        2'b10, 0, 1, 32'h42};
    vecs[11] = '{1, 2'b00, 0, 32'h0,        0, 32'h0,        4,   9,   0, 0,  32'h0,        32'h42,       2'b10, 1, 1, 32'h0};
    vecs[12] = '{1, 2'b00, 0, 32'h0,        0, 32'h0,        2,   9,   1, 2,  32'h0,        32'h42,       2'b10, 1, 2, 32'h0};

    rst = 1'b1;
    en = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    iss_valid = 1'b0; iss_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Every register reads zero after reset, on both ports.
    en = 1'b1;
    for (int r = 1; r < 32; r++) begin
      rd_addr = {5'(32 - r), 5'(r)};
      #1;
      check($sformatf("reset x%0d p0", r), rd_data[31:0], 32'h0);
      check($sformatf("reset x%0d p1", 32 - r), rd_data[63:32], 32'h0);
    end
    check("reset cnt", {26'd0, busy_cnt}, 32'h0);
    check("reset rd_reg", rd_data_r[31:0], 32'h0);

    for (int k = 0; k < 13; k++) apply(vecs[k], k);

    // Reset mid-burst while x2 and x9 are busy: state must clear without a clock edge.
    @(negedge clk);
    en = 1'b1; wr_en = 2'b11;
    wr_addr = {5'd6, 5'd5}; wr_data = {32'h66, 32'h55};
    rd_addr = {5'd9, 5'd2}; iss_valid = 1'b1; iss_addr = 5'd6;
    #1;
    check("pre-rst busy x2", {31'd0, rd_busy[0]}, 32'h1);
    #1;
    rst = 1'b1;
    #1;
    check("rst busy x2", {31'd0, rd_busy[0]}, 32'h0);
    check("rst busy x9", {31'd0, rd_busy[1]}, 32'h0);
    check("rst cnt", {26'd0, busy_cnt}, 32'h0);
    check("rst x9 data", rd_data[63:32], 32'h0);
    check("rst rd_reg", rd_data_r[31:0], 32'h0);
    check("rst cnt_r", {26'd0, busy_cnt_r}, 32'h0);
    @(negedge clk);
    rst = 1'b0; wr_en = '0; iss_valid = 1'b0;
    rd_addr = {5'd3, 5'd7};
    #1;
    check("post-rst x7", rd_data[31:0], 32'h0);
    check("post-rst x3", rd_data[63:32], 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
